// File: rtl/hex_display_pkg.sv
// Shared constants for the scanned hex display: active-low glyph table and
// the nibble-to-segment lookup function.
package hex_display_pkg;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Segment order {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost element.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0011000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

   function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
      return GLYPH_TABLE[nibble];
   endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_seg_lut
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = seg_glyph(nibble);

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed common-anode hex display driver with double-buffered
// contents, leading-zero suppression and per-slot anti-ghosting blanking.
module hex_display_scan
   import hex_display_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  lz_en,
   input  logic                  load,
   output logic [6:0]            seg,
   output logic                  dp_n,
   output logic [DIGITS-1:0]     an,
   output logic                  pending,
   output logic                  frame_done
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W:0] BLANK_LIM = (CNT_W+1)'(BLANK_CYCLES);

   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic                tick;
   logic                boundary;
   logic [4*DIGITS-1:0] pend_value;
   logic [DIGITS-1:0]   pend_dp;
   logic [4*DIGITS-1:0] shadow_value;
   logic [DIGITS-1:0]   shadow_dp;
   logic [3:0]          nibble;
   logic [6:0]          glyph;
   logic                blank;
   logic                suppressed;
   logic [6:0]          seg_next;
   logic                dp_next;
   logic [DIGITS-1:0]   an_next;

   assign tick     = (cnt == CNT_W'(REFRESH_DIV - 1));
   assign boundary = tick && (idx == IDX_W'(DIGITS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (boundary)
            idx <= '0;
         else if (tick)
            idx <= idx + 1'b1;
      end
   end

   // A load landing on the boundary bypasses the pending stage entirely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_value   <= '0;
         pend_dp      <= '0;
         shadow_value <= '0;
         shadow_dp    <= '0;
         pending      <= 1'b0;
      end else if (load) begin
         if (boundary) begin
            shadow_value <= value;
            shadow_dp    <= dp;
            pending      <= 1'b0;
         end else begin
            pend_value <= value;
            pend_dp    <= dp;
            pending    <= 1'b1;
         end
      end else if (boundary && pending) begin
         shadow_value <= pend_value;
         shadow_dp    <= pend_dp;
         pending      <= 1'b0;
      end
   end

   assign nibble     = 4'(shadow_value >> {idx, 2'b00});
   assign blank      = ({1'b0, cnt} < BLANK_LIM);
   // Suppressed when this nibble and every more-significant one are zero.
   assign suppressed = lz_en && (idx != '0) && ((shadow_value >> {idx, 2'b00}) == '0);

   hex_seg_lut u_lut (
      .nibble (nibble),
      .seg    (glyph)
   );

   always_comb begin
      an_next  = '1;
      seg_next = SEG_OFF;
      dp_next  = 1'b1;
      if (!blank) begin
         an_next = ~(DIGITS'(1) << idx);
         if (digit_en[idx]) begin
            dp_next = ~shadow_dp[idx];
            if (!suppressed)
               seg_next = glyph;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg        <= SEG_OFF;
         dp_n       <= 1'b1;
         an         <= '1;
         frame_done <= 1'b0;
      end else begin
         seg        <= seg_next;
         dp_n       <= dp_next;
         an         <= an_next;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_hex_display_scan;

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  digit_en;
   logic        lz_en;
   logic        load;
   logic [6:0]  seg;
   logic        dp_n;
   logic [3:0]  an;
   logic        pending;
   logic        frame_done;

   int n_cmp  = 0;
   int n_fail = 0;
   int unsigned edges;

   hex_display_scan #(
      .DIGITS       (4),
      .REFRESH_DIV  (4),
      .BLANK_CYCLES (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .dp         (dp),
      .digit_en   (digit_en),
      .lz_en      (lz_en),
      .load       (load),
      .seg        (seg),
      .dp_n       (dp_n),
      .an         (an),
      .pending    (pending),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference edge count since reset release; edges%16 is the frame position.
   always @(posedge clk or posedge rst) begin
      if (rst) edges <= 0;
      else     edges <= edges + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic to_pos(input int unsigned r);
      for (int i = 0; i < 17 && (edges % 16) != r; i++) tick();
   endtask

   task automatic load_word(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp    = d;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   task automatic test_reset();
      logic [11:0] got, want;
      rst = 1'b1; value = '0; dp = '0; digit_en = 4'b1111; lz_en = 1'b0; load = 1'b0;
      tick(); tick();
      got = {an, seg, dp_n}; want = {4'b1111, 7'b1111111, 1'b1};
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL reset_outputs got=%h want=%h", got, want); end
      n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b want=0", pending); end
      n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
      rst = 1'b0;
      tick();
      n_cmp++; if (an !== 4'b1111) begin n_fail++; $display("FAIL powerup_blank an got=%b want=1111", an); end
      tick();
      got = {an, seg, dp_n}; want = {4'b1110, 7'b1000000, 1'b1};
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL powerup_first_lit got=%h want=%h", got, want); end
      // Mid-frame asynchronous reset while a load is pending.
      load_word(16'h1234, 4'b1111);
      n_cmp++; if (pending !== 1'b1) begin n_fail++; $display("FAIL pending_rise got=%b want=1", pending); end
      while (edges < 7) tick();
      got = {an, seg, dp_n}; want = {4'b1101, 7'b1000000, 1'b1};
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL premid_digit1 got=%h want=%h", got, want); end
      #2 rst = 1'b1;
      #1;
      got = {an, seg, dp_n}; want = {4'b1111, 7'b1111111, 1'b1};
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL async_reset_outputs got=%h want=%h", got, want); end
      n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL async_reset_pending got=%b want=0", pending); end
      tick();
      rst = 1'b0;
      tick(); tick();
      got = {an, seg, dp_n}; want = {4'b1110, 7'b1000000, 1'b1};
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL rerelease_first_lit got=%h want=%h", got, want); end
   endtask

   task automatic test_basic_scan();
      logic [6:0]  es [4];
      logic [11:0] got, want;
      es = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
      to_pos(3);
      load_word(16'h1A3F, 4'b0000);
      to_pos(0);
      for (int s = 0; s < 16; s++) begin
         tick();
         if (s % 4 == 0) want = {4'b1111, 7'b1111111, 1'b1};
         else            want = {4'b1111 ^ (4'b0001 << (s / 4)), es[s / 4], 1'b1};
         got = {an, seg, dp_n};
         n_cmp++; if (got !== want) begin n_fail++; $display("FAIL basic_scan slot=%0d got=%h want=%h", s, got, want); end
      end
   endtask

   task automatic test_buffering();
      logic [11:0] got, want;
      logic [6:0]  es [4];
      es = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
      to_pos(0);
      for (int s = 0; s < 16; s++) begin
         value = (s == 2) ? 16'h1111 : 16'h2222;
         load  = (s == 2 || s == 8);
         tick();
         load = 1'b0;
         if (s % 4 == 0) want = {4'b1111, 7'b1111111, 1'b1};
         else            want = {4'b1111 ^ (4'b0001 << (s / 4)), es[s / 4], 1'b1};
         got = {an, seg, dp_n};
         n_cmp++; if (got !== want) begin n_fail++; $display("FAIL buf_old_frame slot=%0d got=%h want=%h", s, got, want); end
         n_cmp++; if (pending !== (s >= 2 && s <= 14)) begin n_fail++; $display("FAIL buf_pending slot=%0d got=%b", s, pending); end
         n_cmp++; if (frame_done !== (s == 15)) begin n_fail++; $display("FAIL buf_frame_done slot=%0d got=%b", s, frame_done); end
      end
      for (int s = 0; s < 16; s++) begin
         tick();
         if (s % 4 == 0) want = {4'b1111, 7'b1111111, 1'b1};
         else            want = {4'b1111 ^ (4'b0001 << (s / 4)), 7'b0100100, 1'b1};
         got = {an, seg, dp_n};
         n_cmp++; if (got !== want) begin n_fail++; $display("FAIL buf_new_frame slot=%0d got=%h want=%h", s, got, want); end
         n_cmp++; if (frame_done !== (s == 15)) begin n_fail++; $display("FAIL buf_frame_done2 slot=%0d got=%b", s, frame_done); end
      end
   endtask

   task automatic test_load_boundary();
      logic [11:0] got, want;
      logic [6:0]  es [4];
      es = '{7'b1000000, 7'b1000110, 7'b1000000, 7'b1000000};
      load_word(16'h7777, 4'b0000);
      n_cmp++; if (pending !== 1'b1) begin n_fail++; $display("FAIL lb_pending_set got=%b want=1", pending); end
      to_pos(15);
      load_word(16'h00C0, 4'b0000);
      n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL lb_pending_clear got=%b want=0", pending); end
      n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL lb_frame_done got=%b want=1", frame_done); end
      for (int s = 0; s < 16; s++) begin
         tick();
         if (s % 4 == 0) want = {4'b1111, 7'b1111111, 1'b1};
         else            want = {4'b1111 ^ (4'b0001 << (s / 4)), es[s / 4], 1'b1};
         got = {an, seg, dp_n};
         n_cmp++; if (got !== want) begin n_fail++; $display("FAIL load_boundary slot=%0d got=%h want=%h", s, got, want); end
         n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL lb_pending slot=%0d got=%b want=0", s, pending); end
      end
   endtask

   task automatic test_suppression();
      logic [11:0] got, want;
      logic [6:0]  es [4];
      logic        ed [4];
      es = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
      ed = '{1'b1, 1'b1, 1'b0, 1'b1};
      lz_en = 1'b1;
      load_word(16'h0050, 4'b0100);
      to_pos(0);
      for (int s = 0; s < 16; s++) begin
         tick();
         if (s % 4 == 0) want = {4'b1111, 7'b1111111, 1'b1};
         else            want = {4'b1111 ^ (4'b0001 << (s / 4)), es[s / 4], ed[s / 4]};
         got = {an, seg, dp_n};
         n_cmp++; if (got !== want) begin n_fail++; $display("FAIL suppression slot=%0d got=%h want=%h", s, got, want); end
      end
      lz_en = 1'b0;
   endtask

   task automatic test_enables();
      logic [11:0] got, want;
      logic [6:0]  es [4];
      logic        ed [4];
      es = '{7'b1111111, 7'b0110000, 7'b1111111, 7'b1111001};
      ed = '{1'b1, 1'b0, 1'b1, 1'b0};
      digit_en = 4'b1010;
      load_word(16'h1A3F, 4'b1111);
      to_pos(0);
      for (int s = 0; s < 16; s++) begin
         tick();
         if (s % 4 == 0) want = {4'b1111, 7'b1111111, 1'b1};
         else            want = {4'b1111 ^ (4'b0001 << (s / 4)), es[s / 4], ed[s / 4]};
         got = {an, seg, dp_n};
         n_cmp++; if (got !== want) begin n_fail++; $display("FAIL enables slot=%0d got=%h want=%h", s, got, want); end
      end
      digit_en = 4'b1111;
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_buffering();
      test_load_boundary();
      test_suppression();
      test_enables();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
